// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TXDATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_EMPTY_BIT = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees an entry on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers guard every read, so reset cost buys nothing.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a byte FIFO, STATUS
// reports busy/full/overflow/empty/count, and a bit-timed FSM drives tx_o.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  dbus_en_i,
  input  logic [31:0] dbus_write_addr_i,
  input  logic [31:0] dbus_write_data_i,
  input  logic [31:0] dbus_read_addr_i,
  output logic [31:0] dbus_read_data_o,
  output logic        tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FCW          = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      TXDATA_ADDR = BASE_ADDR + TXDATA_OFF;
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + STATUS_OFF;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;

  logic             push_req, clr_req, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [7:0]       fifo_rdata;
  logic [31:0]      status;
  logic             unused_ok;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .pop_i   (fifo_pop),
    .data_i  (dbus_write_data_i[7:0]),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    push_req = dbus_en_i[0] && (dbus_write_addr_i == TXDATA_ADDR);
    clr_req  = dbus_en_i[0] && (dbus_write_addr_i == STATUS_ADDR)
               && dbus_write_data_i[STAT_OVF_BIT];
    fifo_pop = (state_q == IDLE) && !fifo_empty;
    // A rejected push wins over a simultaneous clear.
    overflow_d = overflow_q;
    if (clr_req) overflow_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d   = fifo_rdata;
          tx_d      = 1'b0;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            // Next line bit is shift_q[1]; the shifted copy keeps it at [0].
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          tx_d      = 1'b1;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    status                                 = '0;
    status[STAT_BUSY_BIT]                  = (state_q != IDLE) || !fifo_empty;
    status[STAT_FULL_BIT]                  = fifo_full;
    status[STAT_OVF_BIT]                   = overflow_q;
    status[STAT_EMPTY_BIT]                 = fifo_empty;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB]  = 9'(fifo_count);
    dbus_read_data_o = (dbus_read_addr_i == STATUS_ADDR) ? status : '0;
  end

  assign tx_o      = tx_q;
  assign unused_ok = ^{dbus_en_i[3:1], dbus_write_data_i[31:8]};

endmodule
